// File: rtl/perf_monitor_if.sv
// Control, event and read-back signals of the performance monitor.
// PERF_SNAPSHOT_EN adds the snap strobe.
interface perf_monitor_if #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int AW         = 6
);
    logic                  en;
    logic                  clr;
    logic [NUM_EVENTS-1:0] event_in;
    logic [31:0]           inst_in;
    logic [AW-1:0]         rd_addr;
`ifdef PERF_SNAPSHOT_EN
    logic                  snap;
`endif
    logic [CNT_WIDTH-1:0]  rd_data;
    logic [NUM_EVENTS:0]   ovf;
    logic                  done;
    logic                  state_dbg;

`ifdef PERF_SNAPSHOT_EN
    modport master (output en, clr, event_in, inst_in, rd_addr, snap,
                    input  rd_data, ovf, done, state_dbg);
    modport slave  (input  en, clr, event_in, inst_in, rd_addr, snap,
                    output rd_data, ovf, done, state_dbg);
`else
    modport master (output en, clr, event_in, inst_in, rd_addr,
                    input  rd_data, ovf, done, state_dbg);
    modport slave  (input  en, clr, event_in, inst_in, rd_addr,
                    output rd_data, ovf, done, state_dbg);
`endif
endinterface

// File: rtl/perf_monitor.sv
// Cycle + event performance counters with end-of-program idle detection.
// PERF_SNAPSHOT_EN adds a shadow bank captured by snap, read with rd_addr MSB=1.
module perf_monitor #(
    parameter int NUM_EVENTS  = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int IDLE_THRESH = 50,
    parameter int SATURATE    = 0,
    parameter int AW          = 6
) (
    input logic          CLK,
    input logic          nrst,
    perf_monitor_if.slave bus
);
    // No valid/ready handshake: every input is sampled on each edge and the
    // read port answers with a fixed one-cycle latency.
    localparam int NCNT = NUM_EVENTS + 1;
    localparam int IW   = $clog2(IDLE_THRESH + 1);
    localparam logic [IW-1:0] THRESH = IW'(IDLE_THRESH);

    typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt [NCNT];
    logic [NUM_EVENTS:0]  ovf_q;
    logic [NUM_EVENTS:0]  inc;
    logic [31:0]          last_inst;
    logic [IW-1:0]        idle_cnt;
    logic [IW-1:0]        idle_nxt;
    logic                 active;
    logic [CNT_WIDTH-1:0] rd_sel;

    // Bit 0 is the cycle counter, which increments on every active cycle.
    assign inc    = {bus.event_in, 1'b1};
    assign active = (state == S_RUN) && bus.en && !bus.clr;

    always_comb begin
        idle_nxt = '0;
        if (bus.inst_in == last_inst)
            idle_nxt = (idle_cnt == THRESH) ? idle_cnt : idle_cnt + IW'(1);
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
            ovf_q     <= '0;
            last_inst <= '0;
            idle_cnt  <= '0;
            state     <= S_RUN;
        end else if (bus.clr) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
            ovf_q     <= '0;
            last_inst <= '0;
            idle_cnt  <= '0;
            state     <= S_RUN;
        end else if (active) begin
            for (int i = 0; i < NCNT; i++) begin
                if (inc[i]) begin
                    if (&cnt[i]) begin
                        ovf_q[i] <= 1'b1;
                        cnt[i]   <= (SATURATE != 0) ? cnt[i] : '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                    end
                end
            end
            last_inst <= bus.inst_in;
            idle_cnt  <= idle_nxt;
            // The final idle cycle is still counted; only later cycles freeze.
            if (idle_nxt == THRESH) state <= S_DONE;
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow [NCNT];
    logic [AW-2:0]        rd_low;

    assign rd_low = bus.rd_addr[AW-2:0];

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NCNT; i++) shadow[i] <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < NCNT; i++) shadow[i] <= '0;
        end else if (bus.snap && state == S_RUN) begin
            for (int i = 0; i < NCNT; i++) shadow[i] <= cnt[i];
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCNT; i++)
            if (rd_low == (AW-1)'(i))
                rd_sel = bus.rd_addr[AW-1] ? shadow[i] : cnt[i];
    end
`else
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCNT; i++)
            if (bus.rd_addr == AW'(i)) rd_sel = cnt[i];
    end
`endif

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) bus.rd_data <= '0;
        else       bus.rd_data <= rd_sel;
    end

    assign bus.ovf       = ovf_q;
    assign bus.done      = (state == S_DONE);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit wrapping instance plus two 8-bit
// instances (wrapping and saturating) that share the same stimulus.
module tb_perf_monitor;
    logic CLK;
    logic nrst;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int inst_seq = 1;

    perf_monitor_if #(.NUM_EVENTS(8), .CNT_WIDTH(32), .AW(6)) bus ();
    perf_monitor_if #(.NUM_EVENTS(8), .CNT_WIDTH(8),  .AW(6)) bus_w ();
    perf_monitor_if #(.NUM_EVENTS(8), .CNT_WIDTH(8),  .AW(6)) bus_s ();

    assign bus_w.en = bus.en;       assign bus_s.en = bus.en;
    assign bus_w.clr = bus.clr;     assign bus_s.clr = bus.clr;
    assign bus_w.event_in = bus.event_in; assign bus_s.event_in = bus.event_in;
    assign bus_w.inst_in = bus.inst_in;   assign bus_s.inst_in = bus.inst_in;
    assign bus_w.rd_addr = bus.rd_addr;   assign bus_s.rd_addr = bus.rd_addr;
`ifdef PERF_SNAPSHOT_EN
    assign bus_w.snap = bus.snap;   assign bus_s.snap = bus.snap;
`endif

    perf_monitor #(.NUM_EVENTS(8), .CNT_WIDTH(32), .IDLE_THRESH(50), .SATURATE(0), .AW(6))
        dut (.CLK(CLK), .nrst(nrst), .bus(bus));
    perf_monitor #(.NUM_EVENTS(8), .CNT_WIDTH(8), .IDLE_THRESH(50), .SATURATE(0), .AW(6))
        dut_w (.CLK(CLK), .nrst(nrst), .bus(bus_w));
    perf_monitor #(.NUM_EVENTS(8), .CNT_WIDTH(8), .IDLE_THRESH(50), .SATURATE(1), .AW(6))
        dut_s (.CLK(CLK), .nrst(nrst), .bus(bus_s));

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n, input logic [7:0] ev);
        for (int i = 0; i < n; i++) begin
            bus.inst_in  = 32'(inst_seq);
            bus.event_in = ev;
            inst_seq++;
            step();
        end
        bus.event_in = '0;
    endtask

    task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
        bus.rd_addr = 6'(addr);
        step();
        check(tag, 64'(bus.rd_data), 64'(exp));
    endtask

    // Scoreboard: reads the whole live bank against the queued expectations
    task automatic check_bank(input string tag);
        for (int a = 0; a < 9; a++) begin
            bus.rd_addr = 6'(a);
            step();
            check($sformatf("%s[%0d]", tag, a), 64'(bus.rd_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic push_bank(input logic [31:0] cyc, input logic [31:0] c0,
                             input logic [31:0] c2, input logic [31:0] rest);
        exp_q.push_back(cyc);
        exp_q.push_back(c0);
        exp_q.push_back(rest);
        exp_q.push_back(c2);
        for (int k = 3; k < 8; k++) exp_q.push_back(rest);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.event_in = '0;
        bus.inst_in = '0;
        bus.rd_addr = '0;
`ifdef PERF_SNAPSHOT_EN
        bus.snap = 1'b0;
`endif
        repeat (3) step();
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);
        nrst = 1'b1;
        step();

        // 100 cycles of distinct instructions, no events
        bus.en = 1'b1;
        run(100, 8'h00);
        bus.en = 1'b0;
        push_bank(100, 0, 0, 0);
        check_bank("t1");
        check("t1_done", 64'(bus.done), 64'd0);
        read_check("t1_oor9", 9, 0);
        read_check("t1_oor63", 63, 0);

        // ch2 for 37 cycles, ch0 for the first 5 of them
        bus.en = 1'b1;
        for (int i = 0; i < 37; i++) run(1, (i < 5) ? 8'h05 : 8'h04);
        bus.en = 1'b0;
        push_bank(137, 5, 37, 0);
        check_bank("t2");

        // Read returns the value before this edge's increment
        bus.en = 1'b1;
        bus.rd_addr = 6'd0;
        run(1, 8'h00);
        check("rd_pre_inc", 64'(bus.rd_data), 64'd137);
        bus.en = 1'b0;

        // Held instruction: first edge loads it, then 50 repeats reach DONE
        bus.en = 1'b1;
        bus.inst_in = 32'h0000006F;
        repeat (50) step();
        check("t3_done_early", 64'(bus.done), 64'd0);
        step();
        check("t3_done_rise", 64'(bus.done), 64'd1);
        check("t3_state", 64'(bus.state_dbg), 64'd1);
        bus.inst_in = 32'h00000013;
        repeat (5) step();
        check("t3_done_sticky", 64'(bus.done), 64'd1);
        read_check("t3_cyc_frozen", 0, 32'd189);
        read_check("t3_ch2_frozen", 3, 32'd37);
        pulse_clr();
        bus.en = 1'b0;
        check("t3_clr_done", 64'(bus.done), 64'd0);
        push_bank(0, 0, 0, 0);
        check_bank("t3_clr");

        // clr beats en and events in the same cycle
        bus.en = 1'b1;
        bus.event_in = 8'hFF;
        pulse_clr();
        bus.en = 1'b0;
        bus.event_in = '0;
        push_bank(0, 0, 0, 0);
        check_bank("t5_clr");
        bus.en = 1'b1;
        run(3, 8'hFF);
        bus.en = 1'b0;
        run(10, 8'hFF);
        push_bank(3, 3, 3, 3);
        check_bank("t5_hold");
        check("t5_ovf", 64'(bus.ovf), 64'd0);

        // 8-bit overflow on ch1: wrap vs saturate
        pulse_clr();
        bus.en = 1'b1;
        run(255, 8'h02);
        bus.en = 1'b0;
        bus.rd_addr = 6'd2;
        step();
        check("t4_w_255", 64'(bus_w.rd_data), 64'hFF);
        check("t4_s_255", 64'(bus_s.rd_data), 64'hFF);
        check("t4_w_ovf_255", 64'(bus_w.ovf), 64'd0);
        bus.en = 1'b1;
        run(1, 8'h02);
        bus.en = 1'b0;
        bus.rd_addr = 6'd2;
        step();
        check("t4_main_256", 64'(bus.rd_data), 64'd256);
        check("t4_w_wrap", 64'(bus_w.rd_data), 64'h00);
        check("t4_s_sat", 64'(bus_s.rd_data), 64'hFF);
        check("t4_w_ovf", 64'(bus_w.ovf), 64'h005);
        check("t4_s_ovf", 64'(bus_s.ovf), 64'h005);
        check("t4_main_ovf", 64'(bus.ovf), 64'd0);
        bus.rd_addr = 6'd0;
        step();
        check("t4_w_cyc", 64'(bus_w.rd_data), 64'h00);
        check("t4_s_cyc", 64'(bus_s.rd_data), 64'hFF);

`ifdef PERF_SNAPSHOT_EN
        pulse_clr();
        bus.en = 1'b1;
        run(20, 8'h00);
        bus.snap = 1'b1;
        run(1, 8'h00);
        bus.snap = 1'b0;
        run(19, 8'h00);
        bus.en = 1'b0;
        read_check("t6_live", 0, 32'd40);
        read_check("t6_shadow", 32, 32'd20);
`endif

        // Asynchronous reset in the middle of counting
        bus.en = 1'b1;
        run(5, 8'hFF);
        nrst = 1'b0;
        #1;
        check("rst_mid_ovf_w", 64'(bus_w.ovf), 64'd0);
        check("rst_mid_rd", 64'(bus.rd_data), 64'd0);
        bus.en = 1'b0;
        step();
        nrst = 1'b1;
        step();
        push_bank(0, 0, 0, 0);
        check_bank("rst_mid");

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
